// File: rtl/fixp_divider.sv
// fixp_divider: sequential signed fixed-point divider, Q4.12 / Q1.6 -> Q2.6.
// Restoring division with one quotient bit per enabled clock and a start/done handshake.
// The quotient saturates on overflow and on divide-by-zero.
// Optional feature macro: DIVIDER_ROUND_EN (round to nearest, ties away from zero).
// Without it the quotient truncates toward zero.
module fixp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        start,
  input  logic [16:0] Y,
  input  logic [7:0]  C,
  output logic        busy,
  output logic        done,
  output logic [8:0]  Q,
  output logic [7:0]  rem,
  output logic        ovf,
  output logic        dz
);

  localparam int unsigned YW = 17;
  localparam int unsigned CW = 8;
  localparam int unsigned QW = 9;
  localparam int unsigned NW = 5;
  localparam int unsigned MW = YW + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   cnt, cnt_nxt;
  logic            fin, fin_nxt;
  logic            sign, sign_nxt;
  logic            ysign, ysign_nxt;
  logic            dzf, dzf_nxt;
  logic [YW-1:0]   ya, ya_nxt;
  logic [CW-1:0]   ca, ca_nxt;
  logic [CW-1:0]   part, part_nxt;
  logic [YW-1:0]   quo, quo_nxt;
  logic            busy_nxt, done_nxt, ovf_nxt, dz_nxt;
  logic [QW-1:0]   q_nxt;
  logic [CW-1:0]   rem_nxt;
  logic [CW:0]     p_sh;
  logic [MW-1:0]   m;

  // State and datapath registers; reset wins over ce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      fin   <= 1'b0;
      sign  <= 1'b0;
      ysign <= 1'b0;
      dzf   <= 1'b0;
      ya    <= '0;
      ca    <= '0;
      part  <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Q     <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else if (ce) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fin   <= fin_nxt;
      sign  <= sign_nxt;
      ysign <= ysign_nxt;
      dzf   <= dzf_nxt;
      ya    <= ya_nxt;
      ca    <= ca_nxt;
      part  <= part_nxt;
      quo   <= quo_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      Q     <= q_nxt;
      rem   <= rem_nxt;
      ovf   <= ovf_nxt;
      dz    <= dz_nxt;
    end
  end

  // Next-state, division step and result formatting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fin_nxt   = fin;
    sign_nxt  = sign;
    ysign_nxt = ysign;
    dzf_nxt   = dzf;
    ya_nxt    = ya;
    ca_nxt    = ca;
    part_nxt  = part;
    quo_nxt   = quo;
    q_nxt     = Q;
    rem_nxt   = rem;
    ovf_nxt   = ovf;
    dz_nxt    = dz;
    p_sh      = {part, ya[YW-1]};
    m         = {1'b0, quo};

    case (state)
      IDLE: begin
        if (start) begin
          sign_nxt  = Y[YW-1] ^ C[CW-1];
          ysign_nxt = Y[YW-1];
          ya_nxt    = Y[YW-1] ? YW'(-Y) : Y;
          ca_nxt    = C[CW-1] ? CW'(-C) : C;
          part_nxt  = '0;
          quo_nxt   = '0;
          cnt_nxt   = NW'(16);
          // A zero divisor skips the iterations and only runs the final step.
          dzf_nxt   = (C == '0);
          fin_nxt   = (C == '0);
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (fin) begin
          fin_nxt   = 1'b0;
          state_nxt = DONE;
          if (dzf) begin
            q_nxt   = ysign ? 9'h100 : 9'h0FF;
            rem_nxt = '0;
            ovf_nxt = 1'b0;
            dz_nxt  = 1'b1;
          end else begin
`ifdef DIVIDER_ROUND_EN
            if ({part, 1'b0} >= {1'b0, ca}) m = m + MW'(1);
`endif
            rem_nxt = part;
            dz_nxt  = 1'b0;
            ovf_nxt = 1'b0;
            if (!sign) begin
              if (m > MW'(255)) begin
                q_nxt   = 9'h0FF;
                ovf_nxt = 1'b1;
              end else begin
                q_nxt = m[QW-1:0];
              end
            end else begin
              if (m > MW'(256)) begin
                q_nxt   = 9'h100;
                ovf_nxt = 1'b1;
              end else begin
                q_nxt = QW'(9'd0 - m[QW-1:0]);
              end
            end
          end
        end else begin
          ya_nxt = {ya[YW-2:0], 1'b0};
          if (p_sh >= {1'b0, ca}) begin
            part_nxt = CW'(p_sh - {1'b0, ca});
            quo_nxt  = {quo[YW-2:0], 1'b1};
          end else begin
            part_nxt = p_sh[CW-1:0];
            quo_nxt  = {quo[YW-2:0], 1'b0};
          end
          if (cnt == '0) fin_nxt = 1'b1;
          else           cnt_nxt = cnt - NW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_fixp_divider.sv
// tb_fixp_divider: scoreboard bench for fixp_divider (directed, stall, reset, random back-to-back).
module tb_fixp_divider;

  typedef struct {
    logic [8:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dz;
    int         lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, start;
  logic [16:0] Y;
  logic [7:0]  C;
  logic        busy, done, ovf, dz;
  logic [8:0]  Q;
  logic [7:0]  rem;

  int   vectors = 0;
  int   errs = 0;
  res_t sb[$];

  fixp_divider dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .Y(Y), .C(C),
    .busy(busy), .done(done), .Q(Q), .rem(rem), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: signed values, integer quotient on the shared LSB grid.
  function automatic res_t model(input logic [16:0] y, input logic [7:0] c);
    res_t e;
    int ys, cs, ay, ac, qm, rr, qs;
    ys = int'($signed(y));
    cs = int'($signed(c));
    ay = (ys < 0) ? -ys : ys;
    ac = (cs < 0) ? -cs : cs;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    if (ac == 0) begin
      e.dz  = 1'b1;
      e.r   = 8'd0;
      e.q   = (ys < 0) ? 9'h100 : 9'h0FF;
      e.lat = 1;
      return e;
    end
    qm = ay / ac;
    rr = ay % ac;
`ifdef DIVIDER_ROUND_EN
    if (2 * rr >= ac) qm = qm + 1;
`endif
    if ((ys < 0) == (cs < 0)) begin
      if (qm > 255) begin qs = 255; e.ovf = 1'b1; end
      else qs = qm;
    end else begin
      if (qm > 256) begin qs = -256; e.ovf = 1'b1; end
      else qs = -qm;
    end
    e.q   = 9'(qs);
    e.r   = 8'(rr);
    e.lat = 18;
    return e;
  endfunction

  // Drives one start pulse at edge 0, then scrambles the inputs.
  task automatic launch(input logic [16:0] y, input logic [7:0] c, input res_t e);
    @(negedge clk);
    Y = y; C = c; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    Y = 17'($urandom);
    C = 8'($urandom);
  endtask

  // Counts enabled-or-not edges until done; optional ce gap and stray start.
  task automatic wait_done(input int ce_lat, input int poke_lat, output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      if (i == ce_lat) ce = 1'b0;
      if (i == ce_lat + 4) ce = 1'b1;
      if (i == poke_lat) begin start = 1'b1; Y = 17'h00100; C = 8'h10; end
      else start = 1'b0;
    end
    start = 1'b0;
    ce = 1'b1;
    if (lat < 0) begin
      vectors++; errs++;
      $display("FAIL timeout: done not seen within 200 cycles");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; Y = '0; C = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, Q, rem, ovf, dz} !== 21'd0) begin
      errs++;
      $display("FAIL reset_state: got %b want 0", {busy, done, Q, rem, ovf, dz});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [16:0] ty[10] = '{17'h01800, 17'h1E800, 17'h01800, 17'd100, 17'h0FFFF,
                            17'h10000, 17'h1FFFB, 17'd5, 17'h10000, 17'd0};
    logic [7:0]  tc[10] = '{8'h20, 8'h20, 8'hE0, 8'h40, 8'h01,
                            8'h01, 8'h00, 8'h00, 8'h80, 8'hFF};
`ifdef DIVIDER_ROUND_EN
    logic [8:0]  tq[10] = '{9'h0C0, 9'h140, 9'h140, 9'd2, 9'h0FF,
                            9'h100, 9'h100, 9'h0FF, 9'h0FF, 9'h000};
`else
    logic [8:0]  tq[10] = '{9'h0C0, 9'h140, 9'h140, 9'd1, 9'h0FF,
                            9'h100, 9'h100, 9'h0FF, 9'h0FF, 9'h000};
`endif
    logic [7:0]  tr[10] = '{8'd0, 8'd0, 8'd0, 8'd36, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [1:0]  tf[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                            2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
    int          lat, extra;
    res_t        e;
    for (int k = 0; k < 10; k++) begin
      e.q = tq[k]; e.r = tr[k]; e.ovf = tf[k][1]; e.dz = tf[k][0];
      e.lat = (tc[k] == 8'h00) ? 1 : 18;
      launch(ty[k], tc[k], e);
      // The second case also gets a stray start mid-run that must be ignored.
      wait_done(-10, (k == 1) ? 5 : -10, lat);
      if (lat < 0 || sb.size() == 0) continue;
      e = sb.pop_front();
      vectors++;
      if ({Q, rem, ovf, dz} !== {e.q, e.r, e.ovf, e.dz}) begin
        errs++;
        $display("FAIL directed[%0d] result: got Q=%h rem=%0d ovf=%b dz=%b want Q=%h rem=%0d ovf=%b dz=%b",
                 k, Q, rem, ovf, dz, e.q, e.r, e.ovf, e.dz);
      end
      vectors++;
      if (lat !== e.lat) begin
        errs++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", k, lat, e.lat);
      end
      @(negedge clk);
      vectors++;
      if ({done, busy, Q} !== {2'b00, e.q}) begin
        errs++;
        $display("FAIL directed[%0d] pulse_hold: got done=%b busy=%b Q=%h want 0 0 %h",
                 k, done, busy, Q, e.q);
      end
      if (k == 1) begin
        extra = 0;
        repeat (25) begin @(negedge clk); if (done) extra++; end
        vectors++;
        if (extra !== 0) begin
          errs++;
          $display("FAIL ignored_start: got %0d extra done pulses want 0", extra);
        end
      end
    end
  endtask

  task automatic test_ce_stall;
    int   lat;
    res_t e;
    launch(17'h01800, 8'h20, model(17'h01800, 8'h20));
    wait_done(5, -10, lat);
    if (lat < 0 || sb.size() == 0) return;
    e = sb.pop_front();
    vectors++;
    if ({Q, rem, ovf, dz} !== {9'h0C0, 8'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL ce_stall result: got Q=%h rem=%0d want Q=0c0 rem=0", Q, rem);
    end
    vectors++;
    if (lat !== e.lat + 4) begin
      errs++;
      $display("FAIL ce_stall latency: got %0d want %0d", lat, e.lat + 4);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    launch(17'h01800, 8'h20, model(17'h01800, 8'h20));
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_front());
    vectors++;
    if ({busy, done, Q, rem, ovf, dz} !== 21'd0) begin
      errs++;
      $display("FAIL reset_mid state: got %b want 0", {busy, done, Q, rem, ovf, dz});
    end
    seen = 0;
    repeat (25) begin @(negedge clk); if (done) seen++; end
    vectors++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL reset_mid done: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic [16:0] y;
    logic [7:0]  c;
    res_t        e;
    for (int k = 0; k < 40; k++) begin
      y = 17'($urandom);
      if (k % 5 == 0) y = {y[16], 7'h00, y[8:0]};
      c = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      launch(y, c, model(y, c));
      wait_done(-10, -10, lat);
      if (lat < 0 || sb.size() == 0) continue;
      e = sb.pop_front();
      vectors++;
      if ({Q, rem, ovf, dz, lat} !== {e.q, e.r, e.ovf, e.dz, e.lat}) begin
        errs++;
        $display("FAIL random[%0d] Y=%h C=%h: got Q=%h rem=%0d ovf=%b dz=%b lat=%0d want Q=%h rem=%0d ovf=%b dz=%b lat=%0d",
                 k, y, c, Q, rem, ovf, dz, lat, e.q, e.r, e.ovf, e.dz, e.lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ce_stall;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
